// File: rtl/alu_pkg.sv
// Shared types, defaults and the full-adder helper for the relay ALU adder stage.
package alu_pkg;

    localparam int unsigned DEF_WIDTH         = 8;
    localparam int unsigned DEF_SETTLE_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RIPPLE = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic sign;
    } alu_flags_t;

    // Returns {carry, sum} of a single-bit full add.
    function automatic logic [1:0] full_add(input logic b, input logic c, input logic ci);
        return {(b & c) | (b & ci) | (c & ci), b ^ c ^ ci};
    endfunction

endpackage

// File: rtl/adder_bit_cell.sv
// Single-bit relay adder cell; provides both carry contacts like the relay original.
module adder_bit_cell
    import alu_pkg::*;
(
    input  logic b_bit,
    input  logic c_bit,
    input  logic carry_in,
    output logic sum_bit,
    output logic carry_out,
    output logic carry_out_n
);

    logic [1:0] fa;

    assign fa          = full_add(b_bit, c_bit, carry_in);
    assign sum_bit     = fa[0];
    assign carry_out   = fa[1];
    assign carry_out_n = ~fa[1];

endmodule

// File: rtl/ripple_adder_sequencer.sv
// Clocked ripple adder: one bit position per settle interval, result and flags
// published only on entry to DONE.
module ripple_adder_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             inc,
    input  logic [WIDTH-1:0] b_reg,
    input  logic [WIDTH-1:0] c_reg,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             zero,
    output logic             sign
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    alu_flags_t       flags_q, flags_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cell_s, cell_co, cell_co_n;
    logic [1:0]       cell_co_pair;
    logic             advance;

    adder_bit_cell u_cell (
        .b_bit       (b_q[idx_q]),
        .c_bit       (c_q[idx_q]),
        .carry_in    (cy_q),
        .sum_bit     (cell_s),
        .carry_out   (cell_co),
        .carry_out_n (cell_co_n)
    );

    // Carry is taken only when the make/break contact pair agrees.
    assign cell_co_pair = {cell_co, cell_co_n};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            b_q     <= '0;
            c_q     <= '0;
            cy_q    <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            flags_q <= '{carry: 1'b0, zero: 1'b1, sign: 1'b0};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cy_q    <= cy_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            flags_q <= flags_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state and ripple datapath
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        c_d     = c_q;
        cy_d    = cy_q;
        acc_d   = acc_q;
        advance = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    b_d     = b_reg;
                    c_d     = inc ? '0 : c_reg;
                    cy_d    = inc;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RIPPLE;
                end
            end
            RIPPLE: begin
                acc_d[idx_q] = cell_s;
                cy_d         = (cell_co_pair == 2'b10);
                if (SETTLE_CYCLES == 1) begin
                    advance = 1'b1;
                end else begin
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = DONE;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = RIPPLE;
            end
        end
    end

    // Registered outputs; result and flags load only on entry to DONE
    always_comb begin
        busy_d  = (state_d == RIPPLE) || (state_d == SETTLE);
        done_d  = (state_d == DONE) && (state_q != DONE);
        sum_d   = sum_q;
        flags_d = flags_q;
        if (done_d) begin
            sum_d         = acc_d;
            flags_d.carry = cy_d;
            flags_d.zero  = (acc_d == '0);
            flags_d.sign  = acc_d[WIDTH-1];
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = flags_q.carry;
    assign zero      = flags_q.zero;
    assign sign      = flags_q.sign;

endmodule

// File: doc/ripple_adder_sequencer.md
# ripple_adder_sequencer

Clocked 8-bit ripple adder stage for the relay ALU. It chains per-bit adder cells and propagates the carry one bit position per settle interval, mimicking relay contact delay. It captures the B and C register operands on a start strobe and presents the sum and condition flags (carry, zero, sign) to the ALU result/condition-code path. It reports completion with a single-cycle done pulse.

## Interface

Parameters:
- WIDTH, 8, operand/sum width in bits
- SETTLE_CYCLES, 2, clocks each bit position takes to settle (≥1)

Ports:
- clk  input  1  system clock (one clock domain)
- reset  input  1  synchronous, active-high reset
- start  input  1  capture operands and begin addition; honoured only in IDLE or DONE
- inc  input  1  when 1, the C operand is forced to 0 and carry-in is forced to 1 (B+1)
- b_reg  input  WIDTH  B operand
- c_reg  input  WIDTH  C operand
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  result, held until the next accepted start
- carry_out  output  1  carry out of the MSB, held with sum
- zero  output  1  1 when sum == 0, held with sum
- sign  output  1  sum[WIDTH-1], held with sum

## Operation

- States:
  - IDLE: waiting for start.
  - RIPPLE: evaluating bit index i.
  - SETTLE: counting SETTLE_CYCLES-1 extra clocks for bit i.
  - DONE: result presented.
- Accepted start (state IDLE or DONE):
  - Latch the B and C operands into internal registers. When inc=1, latch C as 0 and the carry register as 1; otherwise the carry register is 0.
  - Clear the sum register.
  - Set i=0 and go to RIPPLE.
- RIPPLE, bit i:
  - Compute s = b[i]^c[i]^cy and cy' = majority(b[i], c[i], cy).
  - Write s into sum[i] and update cy.
  - If SETTLE_CYCLES==1, advance immediately; otherwise go to SETTLE.
- SETTLE: count down; on expiry, advance.
- Advance: if i==WIDTH-1, go to DONE. Otherwise i++ and return to RIPPLE.
- Entering DONE:
  - carry_out = cy; zero = (sum==0); sign = sum[WIDTH-1].
  - Pulse done for that single cycle. Stay in DONE, with outputs held, until the next start.
- start in RIPPLE/SETTLE is ignored. Operand changes after capture have no effect.
- The sum, carry_out, zero and sign outputs change only on entry to DONE and on reset. The partial sum register is internal, so outputs never show a half-rippled value.
- Arithmetic is modulo 2^WIDTH; overflow appears only through carry_out.

## Timing

- Reset values: state=IDLE, busy=0, done=0, sum=0, carry_out=0, zero=1, sign=0.
- Reset asserted in any state aborts the operation within the same edge and forces the reset values. start is ignored while reset is high.
- Latency: start sampled at edge N → done high during cycle N + WIDTH·SETTLE_CYCLES + 1.
  - With the defaults (WIDTH=8, SETTLE_CYCLES=2), done is high at N+17.
- busy is high from N+1 until the cycle before done is high. busy and done are never high together.
- start in the same cycle as done (state DONE) is accepted, giving back-to-back operations. A new operation therefore begins every WIDTH·SETTLE_CYCLES+1 cycles.

## Structure

- Shared package alu_pkg holds:
  - the state enum type (IDLE, RIPPLE, SETTLE, DONE);
  - the default WIDTH and SETTLE_CYCLES constants;
  - a full_add function returning {carry, sum}.
- Sub-module adder_bit_cell: a combinational single-bit full adder with inputs b_bit, c_bit, carry_in and outputs sum_bit, carry_out, carry_out_n.
  - It is instantiated once and muxed by index i.
  - It keeps the relay per-bit cell boundary for later cross-checking.
- The settle counter is $clog2(SETTLE_CYCLES)+1 bits wide. The bit index is $clog2(WIDTH) bits wide.

## Test plan

- Reset, then B=0x01, C=0x01, start → at 17 cycles after start: done=1, sum=0x02, carry_out=0, zero=0, sign=0.
- B=0xFF, C=0x01 → sum=0x00, carry_out=1, zero=1, sign=0.
- inc=1, B=0x7F, C=0xAA (C ignored) → sum=0x80, carry_out=0, zero=0, sign=1.
- Start with B=0x0F, C=0x01; pulse start again with B=0xF0, C=0xF0 at cycle 5 → the second start is ignored. Result: sum=0x10 with done at cycle 17, with no second done.
- Start B=0x55, C=0xAA; assert reset at cycle 9 → all outputs show reset values at the next cycle, and no done fires. A new start with B=0x03, C=0x04 then gives sum=0x07.
- Back-to-back: issue start in the done cycle with B=0x80, C=0x80 → the second done arrives exactly 17 cycles later with sum=0x00, carry_out=1, zero=1. busy is never high in a done cycle.
